// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder
//   Pipelined segmented ripple-carry adder/subtractor. A WIDTH-bit operand
//   pair is resolved SEG bits per stage. The carry between segments is
//   registered between stages. The final stage register is the output
//   register, so latency is STAGES = WIDTH/SEG cycles. All stages advance
//   together whenever the output is empty or being consumed.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   beat can be accepted this cycle (= !out_valid | out_ready)
//   a, b       operands (WIDTH bits)
//   cin        carry-in, used in add mode only
//   sub        0: a + b + cin, 1: a - b
//   out_valid  result beat valid
//   out_ready  consumer accepts the result
//   sum        result, excluding carry-out (WIDTH bits)
//   cout       carry-out of the MSB (in sub mode this is "no borrow")
//   ovf        two's-complement signed overflow
module seg_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  // Per-stage state. r_a/r_b carry the full (prepared) operands so that
  // the not-yet-resolved upper slices and the MSBs for the overflow flag
  // travel with the beat. r_s holds the sum slices resolved so far.
  logic             r_vld [STAGES];
  logic             r_c   [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];

  logic             w_adv;
  logic [WIDTH-1:0] w_beff;
  logic             w_c0;

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign w_adv    = !r_vld[LAST] | out_ready;
  assign in_ready = w_adv;

  // Subtraction is A + ~B + 1; cin is ignored in that mode.
  assign w_beff = sub ? ~b : b;
  assign w_c0   = sub | cin;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SEG{1'b1}}) << (gi * SEG);

      logic             w_vin;
      logic             w_cin;
      logic [WIDTH-1:0] w_ain;
      logic [WIDTH-1:0] w_bin;
      logic [WIDTH-1:0] w_sin;
      logic [WIDTH-1:0] w_snext;
      logic [SEG:0]     w_seg;

      if (gi == 0) begin : g_head
        assign w_vin = in_valid;
        assign w_ain = a;
        assign w_bin = w_beff;
        assign w_cin = w_c0;
        assign w_sin = '0;
      end else begin : g_body
        assign w_vin = r_vld[gi-1];
        assign w_ain = r_a[gi-1];
        assign w_bin = r_b[gi-1];
        assign w_cin = r_c[gi-1];
        assign w_sin = r_s[gi-1];
      end

      // One SEG-bit ripple segment; bit SEG is the carry into the next stage.
      assign w_seg = {1'b0, w_ain[gi*SEG +: SEG]}
                   + {1'b0, w_bin[gi*SEG +: SEG]}
                   + {{SEG{1'b0}}, w_cin};

      // Merge this stage's slice into the partial sum coming from upstream.
      assign w_snext = (w_sin & ~SLICE_MASK)
                     | (WIDTH'(w_seg[SEG-1:0]) << (gi * SEG));

      // Data registers load only with a valid beat, so a bubble reaching
      // the output leaves the last result on sum/cout/ovf.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld[gi] <= 1'b0;
          r_c[gi]   <= 1'b0;
          r_a[gi]   <= '0;
          r_b[gi]   <= '0;
          r_s[gi]   <= '0;
        end else if (w_adv) begin
          r_vld[gi] <= w_vin;
          if (w_vin) begin
            r_c[gi] <= w_seg[SEG];
            r_a[gi] <= w_ain;
            r_b[gi] <= w_bin;
            r_s[gi] <= w_snext;
          end
        end
      end
    end
  endgenerate

  assign out_valid = r_vld[LAST];
  assign sum       = r_s[LAST];
  assign cout      = r_c[LAST];
  // Same-sign operands producing a result of the other sign. All terms
  // are final-stage registers, so the flag is as stable as sum.
  assign ovf = (r_a[LAST][WIDTH-1] == r_b[LAST][WIDTH-1])
             & (r_s[LAST][WIDTH-1] != r_a[LAST][WIDTH-1]);

endmodule

// File: doc/seg_pipe_adder.md
Name: seg_pipe_adder

Overview:
Parametrised, pipelined segmented ripple-carry adder/subtractor. It generalises the fixed 16-bit ripple-carry adder to WIDTH bits, split into SEG-bit segments. One segment is resolved per pipeline stage, with the carry registered between stages. A valid/ready handshake on both sides carries back-pressure, and the block adds a subtract mode and a signed-overflow flag. It sits between stream producers and consumers in the datapath and in the file-driven verification flow.

Parameters:
WIDTH, 16, operand and sum width in bits; must be a multiple of SEG.
SEG, 4, bits resolved per pipeline stage; STAGES = WIDTH/SEG, and STAGES must be at least 1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add mode only)
sub  input  1  0 = A+B+cin, 1 = A-B
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts the result
sum  output  WIDTH  result, excluding carry-out
cout  output  1  carry-out; in sub mode this is NOT borrow
ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset, applied asynchronously:
  - out_valid=0, sum=0, cout=0, ovf=0.
  - All stage valid bits, carries and partial sums clear to 0.
  - in_ready follows its equation below, so it reads 1 once reset is applied.
- Reset mid-operation discards every in-flight beat; no partial result is ever presented.
- Operand preparation at input capture:
  - B_eff = sub ? ~b : b.
  - C0 = sub ? 1 : cin; cin is ignored when sub=1.
- Pipeline structure:
  - Stage k (k = 0..STAGES-1) adds bits [k*SEG +: SEG] of A and B_eff with the carry from stage k-1 (C0 for k=0).
  - It registers that SEG-bit slice, the carry out, and a valid bit.
  - Unresolved upper operand bits and already-resolved lower sum bits travel alongside in skew registers.
- Timing:
  - Latency is STAGES cycles from input acceptance (in_valid & in_ready at a clk edge) to out_valid=1.
  - Throughput is one beat per cycle when out_ready=1.
- Advance rule:
  - adv = !out_valid | out_ready, and in_ready = adv.
  - All stages shift together when adv=1 and hold when adv=0; this is a global stall.
  - Bubbles (invalid stages) shift through like data; they are not collapsed.
- Output register:
  - sum, cout and ovf hold stable while out_valid=1 and out_ready=0.
  - They update only on an advance.
- ovf = (A[W-1] == B_eff[W-1]) & (sum[W-1] != A[W-1]).
  - It is computed from the registered operand MSBs at the final stage.
- cout = carry out of bit WIDTH-1 of A + B_eff + C0.
- Accepted operand bits and mode are frozen in the pipeline; later changes on a, b, cin or sub do not affect in-flight beats.
- in_valid=0 when adv=1 injects a bubble.
- out_ready=1 with out_valid=0 is legal and has no effect.
- Simultaneous accept and output in the same cycle is required at full rate.
- STAGES=1 (SEG=WIDTH) gives a single registered adder with a latency of 1.

Test Plan:
(WIDTH=16, SEG=4, latency 4 unless stated)
- Carry ripple through all segments, sign-wrap overflow:
  - Stimulus: a=FFFF, b=0001, cin=0, sub=0.
  - Response: after 4 cycles sum=0000, cout=1, ovf=0.
  - Then a=7FFF, b=0001 → sum=8000, cout=0, ovf=1.
- Subtract without and with borrow:
  - sub=1, a=0005, b=0003, cin=1 → sum=0002, cout=1, ovf=0 (cin ignored).
  - a=0003, b=0005 → sum=FFFE, cout=0.
  - a=8000, b=0001 → sum=7FFF, ovf=1.
- Full-rate stream:
  - Stimulus: 256 back-to-back beats from the in-file (hex operand pairs), out_ready held 1.
  - Response: 256 results in order, one per cycle, starting cycle 4.
  - Each out-file line matches a+b+cin mod 2^17 for the Python checker.
- Back-pressure:
  - Stimulus: stream with out_ready=0 for 5 cycles while out_valid=1.
  - Response: in_ready=0 and sum/cout/ovf stable for those cycles; no beat lost or duplicated when released.
- Reset mid-flight:
  - Stimulus: assert rst asynchronously (between edges) with 3 beats in flight.
  - Response: outputs read 0 immediately; no stale beats appear after release; first new beat appears 4 cycles after acceptance.
- Parameter sweep:
  - Stimulus: WIDTH=32/SEG=8 and WIDTH=8/SEG=8.
  - Response: latency 4 and 1 respectively; FFFFFFFF+1 → 00000000 with cout=1.
